// File: rtl/letc_core_pkg.sv
// Shared LETC core types for the atomic-memory-operation path: request kinds,
// AMO ALU opcodes, sequencer states and the SC result constants.
package letc_core_pkg;

  typedef enum logic [1:0] {
    AMO_KIND_AMO = 2'd0,
    AMO_KIND_LR  = 2'd1,
    AMO_KIND_SC  = 2'd2
  } amo_kind_e;

  typedef enum logic [3:0] {
    AMO_OP_SWAP = 4'd0,
    AMO_OP_ADD  = 4'd1,
    AMO_OP_AND  = 4'd2,
    AMO_OP_OR   = 4'd3,
    AMO_OP_XOR  = 4'd4,
    AMO_OP_MIN  = 4'd5,
    AMO_OP_MAX  = 4'd6,
    AMO_OP_MINU = 4'd7,
    AMO_OP_MAXU = 4'd8
  } amo_alu_op_e;

  typedef enum logic [2:0] {
    AMO_SEQ_IDLE    = 3'd0,
    AMO_SEQ_RD_REQ  = 3'd1,
    AMO_SEQ_RD_WAIT = 3'd2,
    AMO_SEQ_WR_REQ  = 3'd3,
    AMO_SEQ_WR_WAIT = 3'd4,
    AMO_SEQ_DRAIN   = 3'd5,
    AMO_SEQ_DONE    = 3'd6
  } amo_seq_state_e;

  localparam logic [31:0] SC_FAIL_VAL   = 32'd1;
  localparam logic [31:0] SC_OK_VAL     = 32'd0;
  localparam logic [31:0] AMO_UNDEF_VAL = 32'hDEADBEEF;

endpackage

// File: rtl/letc_core_amo_sequencer_if.sv
// Valid/ready data-memory (DMSS) port used by the AMO sequencer.
// master = requester (sequencer), slave = DMSS.
interface letc_core_amo_sequencer_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/letc_core_amo_alu.sv
// Combinational RV32A read-modify-write ALU. Shared with the memory2 datapath
// so the AMO semantics live in exactly one place.
module letc_core_amo_alu
  import letc_core_pkg::*;
(
  input  amo_alu_op_e i_op,
  input  logic [31:0] i_mem_rdata,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_result
);

  // Select the new memory word from the old word and rs2.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_result unassigned (no latch).
    o_result = AMO_UNDEF_VAL;
    case (i_op)
      AMO_OP_SWAP: o_result = i_rs2;
      AMO_OP_ADD:  o_result = i_mem_rdata + i_rs2;
      AMO_OP_AND:  o_result = i_mem_rdata & i_rs2;
      AMO_OP_OR:   o_result = i_mem_rdata | i_rs2;
      AMO_OP_XOR:  o_result = i_mem_rdata ^ i_rs2;
      AMO_OP_MIN:  o_result = ($signed(i_mem_rdata) < $signed(i_rs2)) ? i_mem_rdata : i_rs2;
      AMO_OP_MAX:  o_result = ($signed(i_mem_rdata) > $signed(i_rs2)) ? i_mem_rdata : i_rs2;
      AMO_OP_MINU: o_result = (i_mem_rdata < i_rs2) ? i_mem_rdata : i_rs2;
      AMO_OP_MAXU: o_result = (i_mem_rdata > i_rs2) ? i_mem_rdata : i_rs2;
      default:     o_result = AMO_UNDEF_VAL;
    endcase
  end

endmodule

// File: rtl/letc_core_amo_sequencer.sv
// RV32A sequencer: runs AMO / LR.W / SC.W as a load and optional store on the
// single DMSS port, stalls the pipeline while doing so and owns the LR/SC
// reservation. Build option: define LETC_CORE_AMO_LRSC_EN to include the
// reservation register; without it LR is a plain load and SC always fails.
module letc_core_amo_sequencer
  import letc_core_pkg::*;
#(
  parameter int unsigned RESV_GRAN_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  amo_kind_e   req_kind,
  input  amo_alu_op_e req_amo_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  input  logic        resv_clear,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd_val,
  output logic        rsp_misaligned,
  letc_core_amo_sequencer_if.master dmss
);

  amo_seq_state_e r_state;
  amo_seq_state_e w_next_state;
  amo_kind_e      r_kind;
  amo_alu_op_e    r_op;
  logic [29:0]    r_addr;        // word address of the operation
  logic [31:0]    r_rs2;
  logic [31:0]    r_wdata;
  logic [31:0]    r_rd_val;
  logic           r_misaligned;

  logic           w_accept;
  logic           w_misaligned_in;
  logic           w_resv_match;
  logic           w_rd_rsp;      // read data arriving and the op is not being flushed
  logic [31:0]    w_alu_result;

  assign w_accept        = req_valid && req_ready;
  assign w_misaligned_in = |req_addr[1:0];
  assign w_rd_rsp        = (r_state == AMO_SEQ_RD_WAIT) && dmss.mem_rsp_valid && !flush;

  letc_core_amo_alu u_alu (
    .i_op        (r_op),
    .i_mem_rdata (dmss.mem_rsp_rdata),
    .i_rs2       (r_rs2),
    .o_result    (w_alu_result)
  );

`ifdef LETC_CORE_AMO_LRSC_EN
  logic                     r_resv_valid;
  logic [31:RESV_GRAN_LOG2] r_resv_tag;

  assign w_resv_match = r_resv_valid && (r_resv_tag == req_addr[31:RESV_GRAN_LOG2]);

  // Reservation: clear has priority over an LR completing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resv_valid <= 1'b0;
      r_resv_tag   <= '0;
    end else if (resv_clear) begin
      r_resv_valid <= 1'b0;
    end else if (w_accept && req_kind == AMO_KIND_SC) begin
      r_resv_valid <= 1'b0;
    end else if (w_rd_rsp && r_kind == AMO_KIND_LR) begin
      r_resv_valid <= 1'b1;
      r_resv_tag   <= r_addr[29:RESV_GRAN_LOG2-2];
    end
  end
`else
  // No reservation is ever held, so every SC fails without touching memory.
  logic        w_unused_resv_clear;
  logic [31:0] w_unused_gran;
  assign w_unused_resv_clear = resv_clear;
  assign w_unused_gran       = 32'(RESV_GRAN_LOG2);
  assign w_resv_match        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= AMO_SEQ_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    w_next_state       = r_state;
    req_ready          = 1'b0;
    busy               = 1'b1;
    rsp_valid          = 1'b0;
    rsp_misaligned     = 1'b0;
    dmss.mem_req_valid = 1'b0;
    dmss.mem_req_we    = 1'b0;
    case (r_state)
      AMO_SEQ_IDLE: begin
        busy      = 1'b0;
        // A flush in IDLE suppresses a same-cycle accept.
        req_ready = !flush;
        if (w_accept) begin
          if (w_misaligned_in)              w_next_state = AMO_SEQ_DONE;
          else if (req_kind == AMO_KIND_SC) w_next_state = w_resv_match ? AMO_SEQ_WR_REQ : AMO_SEQ_DONE;
          else                              w_next_state = AMO_SEQ_RD_REQ;
        end
      end
      AMO_SEQ_RD_REQ: begin
        // Withdraw the unaccepted read on flush so no response is owed.
        dmss.mem_req_valid = !flush;
        if (flush)                   w_next_state = AMO_SEQ_IDLE;
        else if (dmss.mem_req_ready) w_next_state = AMO_SEQ_RD_WAIT;
      end
      AMO_SEQ_RD_WAIT: begin
        if (flush) begin
          // If the response is already here it is simply dropped.
          w_next_state = dmss.mem_rsp_valid ? AMO_SEQ_IDLE : AMO_SEQ_DRAIN;
        end else if (dmss.mem_rsp_valid) begin
          w_next_state = (r_kind == AMO_KIND_LR) ? AMO_SEQ_DONE : AMO_SEQ_WR_REQ;
        end
      end
      AMO_SEQ_WR_REQ: begin
        dmss.mem_req_valid = 1'b1;
        dmss.mem_req_we    = 1'b1;
        if (dmss.mem_req_ready) w_next_state = AMO_SEQ_WR_WAIT;
      end
      AMO_SEQ_WR_WAIT: begin
        if (dmss.mem_rsp_valid) w_next_state = AMO_SEQ_DONE;
      end
      AMO_SEQ_DRAIN: begin
        if (dmss.mem_rsp_valid) w_next_state = AMO_SEQ_IDLE;
      end
      AMO_SEQ_DONE: begin
        rsp_valid      = 1'b1;
        rsp_misaligned = r_misaligned;
        w_next_state   = AMO_SEQ_IDLE;
      end
      default: w_next_state = AMO_SEQ_IDLE;
    endcase
  end

  // Operand capture, store data and rd value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kind       <= AMO_KIND_AMO;
      r_op         <= AMO_OP_SWAP;
      r_addr       <= '0;
      r_rs2        <= '0;
      r_wdata      <= '0;
      r_rd_val     <= '0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_accept) begin
        r_kind       <= req_kind;
        r_op         <= req_amo_op;
        r_addr       <= req_addr[31:2];
        r_rs2        <= req_rs2;
        r_wdata      <= req_rs2;
        r_misaligned <= w_misaligned_in;
        // Failed-SC value; overwritten later by every path that reaches memory.
        r_rd_val     <= w_misaligned_in ? 32'd0 : SC_FAIL_VAL;
      end
      if (w_rd_rsp) begin
        r_rd_val <= dmss.mem_rsp_rdata;
        r_wdata  <= w_alu_result;
      end
      if (r_state == AMO_SEQ_WR_WAIT && dmss.mem_rsp_valid && r_kind == AMO_KIND_SC) begin
        r_rd_val <= SC_OK_VAL;
      end
    end
  end

  assign dmss.mem_req_addr  = {r_addr, 2'b00};
  assign dmss.mem_req_wdata = r_wdata;
  assign rsp_rd_val         = r_rd_val;

endmodule

// File: tb/tb_letc_core_amo_sequencer.sv
// Directed bench for letc_core_amo_sequencer with a small DMSS model whose
// ready and response delay are steerable. Expectations follow the build option
// LETC_CORE_AMO_LRSC_EN.
module tb_letc_core_amo_sequencer;
  import letc_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  amo_kind_e   req_kind;
  amo_alu_op_e req_amo_op;
  logic [31:0] req_addr;
  logic [31:0] req_rs2;
  logic        flush;
  logic        resv_clear;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rd_val;
  logic        rsp_misaligned;
  logic        ready_en;

  int n_checks = 0;
  int n_fail   = 0;

  letc_core_amo_sequencer_if bus ();
  assign bus.mem_req_ready = ready_en;

  letc_core_amo_sequencer #(.RESV_GRAN_LOG2(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_kind       (req_kind),
    .req_amo_op     (req_amo_op),
    .req_addr       (req_addr),
    .req_rs2        (req_rs2),
    .flush          (flush),
    .resv_clear     (resv_clear),
    .busy           (busy),
    .rsp_valid      (rsp_valid),
    .rsp_rd_val     (rsp_rd_val),
    .rsp_misaligned (rsp_misaligned),
    .dmss           (bus)
  );

  always #5 clk = ~clk;

  // DMSS model: word memory, accept counters, response after rsp_delay cycles.
  logic [31:0] mem_model [logic [31:0]];
  int          rsp_delay = 1;
  int          acc_cnt   = 0;
  int          wr_cnt    = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_rd_addr = '0;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'd0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] d;
    if (!rst_n) begin
      bus.mem_rsp_valid <= 1'b0;
      bus.mem_rsp_rdata <= '0;
      pend              <= 1'b0;
      pend_cnt          <= 0;
      pend_data         <= '0;
    end else begin
      bus.mem_rsp_valid <= 1'b0;
      if (pend) begin
        if (pend_cnt == 1) begin
          bus.mem_rsp_valid <= 1'b1;
          bus.mem_rsp_rdata <= pend_data;
          pend              <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        acc_cnt++;
        if (bus.mem_req_we) begin
          mem_model[bus.mem_req_addr] = bus.mem_req_wdata;
          wr_cnt++;
          last_wr_addr = bus.mem_req_addr;
          d = 32'd0;
        end else begin
          last_rd_addr = bus.mem_req_addr;
          d = mem_rd(bus.mem_req_addr);
        end
        if (rsp_delay <= 1) begin
          bus.mem_rsp_valid <= 1'b1;
          bus.mem_rsp_rdata <= d;
        end else begin
          pend      <= 1'b1;
          pend_cnt  <= rsp_delay - 1;
          pend_data <= d;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request; returns at the negedge after the accepting edge.
  task automatic send_req(input amo_kind_e k, input amo_alu_op_e op,
                          input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_kind   = k;
    req_amo_op = op;
    req_addr   = a;
    req_rs2    = d;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Wait for rsp_valid; lat counts the accept cycle as cycle 1.
  task automatic wait_rsp(input string tag, output logic [31:0] rd, output logic mis, output int lat);
    logic got;
    got = 1'b0;
    rd  = '0;
    mis = 1'b0;
    lat = 2;
    while (!got && lat < 100) begin
      if (rsp_valid) begin
        got = 1'b1;
        rd  = rsp_rd_val;
        mis = rsp_misaligned;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic do_op(input string tag, input amo_kind_e k, input amo_alu_op_e op,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic mis, output int lat);
    send_req(k, op, a, d);
    wait_rsp(tag, rd, mis, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          acc0;
    int          wr0;
    int          nrsp;
    logic        found;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_kind   = AMO_KIND_AMO;
    req_amo_op = AMO_OP_SWAP;
    req_addr   = '0;
    req_rs2    = '0;
    flush      = 1'b0;
    resv_clear = 1'b0;
    ready_en   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_mis", {31'd0, rsp_misaligned}, 32'd0);
    check("rst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_req_we}, 32'd0);
    check("rst_rd_val", rsp_rd_val, 32'd0);
    check("rst_mem_addr", bus.mem_req_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_req_wdata, 32'd0);
    rst_n = 1'b1;

    // AMOADD: 7 + 5, zero-wait memory.
    mem_model[32'h100] = 32'h7;
    do_op("add", AMO_KIND_AMO, AMO_OP_ADD, 32'h100, 32'h5, rd, mis, lat);
    check("add_rd", rd, 32'h7);
    check("add_lat", lat, 6);
    check("add_mis", {31'd0, mis}, 32'd0);
    check("add_mem", mem_rd(32'h100), 32'hC);
    check("add_rd_addr", last_rd_addr, 32'h100);
    check("add_wr_addr", last_wr_addr, 32'h100);
    @(negedge clk);
    check("add_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check("add_ready_back", {31'd0, req_ready}, 32'd1);

    // Signed versus unsigned minimum on 0xFFFFFFFF and 1.
    mem_model[32'h140] = 32'hFFFF_FFFF;
    do_op("min", AMO_KIND_AMO, AMO_OP_MIN, 32'h140, 32'h1, rd, mis, lat);
    check("min_rd", rd, 32'hFFFF_FFFF);
    check("min_mem", mem_rd(32'h140), 32'hFFFF_FFFF);
    mem_model[32'h144] = 32'hFFFF_FFFF;
    do_op("minu", AMO_KIND_AMO, AMO_OP_MINU, 32'h144, 32'h1, rd, mis, lat);
    check("minu_rd", rd, 32'hFFFF_FFFF);
    check("minu_mem", mem_rd(32'h144), 32'h1);

    // MAX (signed), SWAP, XOR and an undefined opcode.
    mem_model[32'h148] = 32'h8000_0000;
    do_op("max", AMO_KIND_AMO, AMO_OP_MAX, 32'h148, 32'h1, rd, mis, lat);
    check("max_mem", mem_rd(32'h148), 32'h1);
    mem_model[32'h14C] = 32'h1234;
    do_op("swap", AMO_KIND_AMO, AMO_OP_SWAP, 32'h14C, 32'h55, rd, mis, lat);
    check("swap_rd", rd, 32'h1234);
    check("swap_mem", mem_rd(32'h14C), 32'h55);
    mem_model[32'h158] = 32'hF0F0_00FF;
    do_op("xor", AMO_KIND_AMO, AMO_OP_XOR, 32'h158, 32'h0FF0_0F0F, rd, mis, lat);
    check("xor_mem", mem_rd(32'h158), 32'hFF00_0FF0);
    mem_model[32'h150] = 32'h1;
    do_op("undef", AMO_KIND_AMO, amo_alu_op_e'(4'hF), 32'h150, 32'h2, rd, mis, lat);
    check("undef_rd", rd, 32'h1);
    check("undef_mem", mem_rd(32'h150), 32'hDEADBEEF);

    // LR then SC in the same 16-byte granule, then a second SC.
    mem_model[32'h200] = 32'h11;
    mem_model[32'h204] = 32'h33;
    do_op("lr", AMO_KIND_LR, AMO_OP_SWAP, 32'h200, 32'h0, rd, mis, lat);
    check("lr_rd", rd, 32'h11);
    check("lr_lat", lat, 4);
    acc0 = acc_cnt;
    do_op("sc1", AMO_KIND_SC, AMO_OP_SWAP, 32'h204, 32'hAA, rd, mis, lat);
`ifdef LETC_CORE_AMO_LRSC_EN
    check("sc1_rd", rd, 32'h0);
    check("sc1_lat", lat, 4);
    check("sc1_mem", mem_rd(32'h204), 32'hAA);
    check("sc1_acc", acc_cnt - acc0, 1);
`else
    check("sc1_rd", rd, 32'h1);
    check("sc1_lat", lat, 2);
    check("sc1_mem", mem_rd(32'h204), 32'h33);
    check("sc1_acc", acc_cnt - acc0, 0);
`endif
    acc0 = acc_cnt;
    do_op("sc2", AMO_KIND_SC, AMO_OP_SWAP, 32'h204, 32'hBB, rd, mis, lat);
    check("sc2_rd", rd, 32'h1);
    check("sc2_lat", lat, 2);
    check("sc2_acc", acc_cnt - acc0, 0);

`ifdef LETC_CORE_AMO_LRSC_EN
    // SC to the next granule fails.
    do_op("lr_g", AMO_KIND_LR, AMO_OP_SWAP, 32'h200, 32'h0, rd, mis, lat);
    acc0 = acc_cnt;
    do_op("sc_g", AMO_KIND_SC, AMO_OP_SWAP, 32'h210, 32'hCC, rd, mis, lat);
    check("sc_g_rd", rd, 32'h1);
    check("sc_g_acc", acc_cnt - acc0, 0);
`endif

    // LR, resv_clear pulse, SC to the same address.
    do_op("lr_c", AMO_KIND_LR, AMO_OP_SWAP, 32'h200, 32'h0, rd, mis, lat);
    @(negedge clk);
    resv_clear = 1'b1;
    @(negedge clk);
    resv_clear = 1'b0;
    acc0 = acc_cnt;
    do_op("sc_c", AMO_KIND_SC, AMO_OP_SWAP, 32'h200, 32'h77, rd, mis, lat);
    check("sc_c_rd", rd, 32'h1);
    check("sc_c_acc", acc_cnt - acc0, 0);
    check("sc_c_mem", mem_rd(32'h200), 32'h11);

    // Misaligned AMO: no memory access, 2-cycle response.
    acc0 = acc_cnt;
    do_op("mis", AMO_KIND_AMO, AMO_OP_ADD, 32'h102, 32'h1, rd, mis, lat);
    check("mis_flag", {31'd0, mis}, 32'd1);
    check("mis_lat", lat, 2);
    check("mis_acc", acc_cnt - acc0, 0);

    // Read request held while the DMSS is not ready.
    mem_model[32'h300] = 32'h1;
    ready_en = 1'b0;
    send_req(AMO_KIND_AMO, AMO_OP_ADD, 32'h300, 32'h2);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("stall_addr", bus.mem_req_addr, 32'h300);
      check("stall_we", {31'd0, bus.mem_req_we}, 32'd0);
      @(negedge clk);
    end
    ready_en = 1'b1;
    wait_rsp("stall", rd, mis, lat);
    check("stall_rd", rd, 32'h1);
    check("stall_mem", mem_rd(32'h300), 32'h3);

    // Flush in RD_WAIT: the late response is drained, nothing completes.
    mem_model[32'h400] = 32'h9;
    rsp_delay = 3;
    wr0 = wr_cnt;
    send_req(AMO_KIND_AMO, AMO_OP_ADD, 32'h400, 32'h1);
    check("fl_rd_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    check("fl_rd_no_rsp", nrsp, 0);
    check("fl_rd_ready", {31'd0, req_ready}, 32'd1);
    check("fl_rd_busy_end", {31'd0, busy}, 32'd0);
    check("fl_rd_no_wr", wr_cnt - wr0, 0);
    check("fl_rd_mem", mem_rd(32'h400), 32'h9);

    // Flush in WR_WAIT: the store is committed and the op still completes.
    mem_model[32'h500] = 32'hF0;
    send_req(AMO_KIND_AMO, AMO_OP_OR, 32'h500, 32'h0F);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req_valid && bus.mem_req_we) found = 1'b1;
      else @(negedge clk);
    end
    check("fl_wr_store_seen", {31'd0, found}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_rsp("fl_wr", rd, mis, lat);
    check("fl_wr_rd", rd, 32'hF0);
    check("fl_wr_mem", mem_rd(32'h500), 32'hFF);
    rsp_delay = 1;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
